// File: rtl/reel_spin_ctrl_if.sv
// Request/status bundle between the slot-machine game logic and the reel spin controller.
// Game logic drives up/down; the controller drives the reel offsets and spin status.
interface reel_spin_ctrl_if #(
    parameter int NUM_REELS = 3,
    parameter int POS_W     = 10
);
    logic                         up;
    logic                         down;
    logic [NUM_REELS*POS_W-1:0]   pos;
    logic [NUM_REELS-1:0]         moving;
    logic                         busy;
    logic                         done;
    logic                         dir;

    modport master (output up, down, input pos, moving, busy, done, dir);
    modport slave  (input up, down, output pos, moving, busy, done, dir);
endinterface

// File: rtl/reel_spin_ctrl.sv
// N-reel spin controller: one accelerate/cruise/decelerate spin per request, reels stop staggered.
// Optional macro REEL_SNAP_EN: after its profile each reel creeps at speed 1 until symbol-aligned.
module reel_spin_ctrl #(
    parameter int NUM_REELS = 3,
    parameter int POS_W     = 10,
    parameter int WRAP      = 240,
    parameter int CNT_W     = 11,
    parameter int ACCEL     = 120,
    parameter int BASE_STOP = 600,
    parameter int STAGGER   = 200,
    parameter int SLOW_SPD  = 1,
    parameter int MID_SPD   = 2,
    parameter int FAST_SPD  = 3,
    parameter int SYM_H     = 80
) (
    input  logic              clk,
    input  logic              rst,
    reel_spin_ctrl_if.slave   bus
);

    localparam int              T_LAST_I = BASE_STOP + (NUM_REELS - 1) * STAGGER;
    localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(T_LAST_I);

    logic [CNT_W-1:0]                   cnt_r;
    logic [NUM_REELS-1:0][POS_W-1:0]    pos_r;
    logic                               dir_r;
    logic                               done_r;
    logic [NUM_REELS-1:0][POS_W:0]      spd_s;
    logic [NUM_REELS-1:0][POS_W-1:0]    nxt_pos_s;
    logic [NUM_REELS-1:0]               moving_s;
    logic                               finish_s;
`ifdef REEL_SNAP_EN
    logic                               past_r;
    logic                               all_aligned_s;
`endif

    // Speed profile of reel idx at timer value c; T_i shifts the deceleration ramp per reel.
    function automatic logic [POS_W:0] profile_speed(input logic [CNT_W-1:0] c, input int idx);
        int               t;
        int               ci;
        logic [POS_W:0]   s;
        t  = BASE_STOP + idx * STAGGER;
        ci = int'(c);
        if (ci == 0 || ci > t)            s = '0;
        else if (ci <= ACCEL)             s = (POS_W+1)'(SLOW_SPD);
        else if (ci <= 2 * ACCEL)         s = (POS_W+1)'(MID_SPD);
        else if (ci <= t - 2 * ACCEL)     s = (POS_W+1)'(FAST_SPD);
        else if (ci <= t - ACCEL)         s = (POS_W+1)'(MID_SPD);
        else                              s = (POS_W+1)'(SLOW_SPD);
        return s;
    endfunction

    // Wrap-around step; one extra bit keeps pos+WRAP and pos+s from overflowing.
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p_in,
                                                  input logic [POS_W:0]   s,
                                                  input logic             d);
        logic [POS_W:0] p;
        logic [POS_W:0] w;
        logic [POS_W:0] r;
        p = {1'b0, p_in};
        w = (POS_W+1)'(WRAP);
        if (d) begin
            if (p < s) r = (p + w) - s;
            else       r = p - s;
        end else begin
            if (p + s >= w) r = (p + s) - w;
            else            r = p + s;
        end
        return r[POS_W-1:0];
    endfunction

    // Per-reel speed, next position and motion flag.
    always_comb begin
        spd_s     = '0;
        nxt_pos_s = pos_r;
        moving_s  = '0;
`ifdef REEL_SNAP_EN
        all_aligned_s = 1'b1;
`endif
        for (int i = 0; i < NUM_REELS; i++) begin
`ifdef REEL_SNAP_EN
            if (past_r || int'(cnt_r) > BASE_STOP + i * STAGGER) begin
                if (int'(pos_r[i]) % SYM_H != 0) spd_s[i] = (POS_W+1)'(1);
                else                             spd_s[i] = '0;
            end else begin
                spd_s[i] = profile_speed(cnt_r, i);
            end
`else
            spd_s[i] = profile_speed(cnt_r, i);
`endif
            nxt_pos_s[i] = step_pos(pos_r[i], spd_s[i], dir_r);
            moving_s[i]  = (spd_s[i] != '0);
`ifdef REEL_SNAP_EN
            if (int'(nxt_pos_s[i]) % SYM_H != 0) all_aligned_s = 1'b0;
            else                                 all_aligned_s = all_aligned_s;
`endif
        end
    end

    // The spin ends at T_LAST, or later once every reel has crept onto a symbol boundary.
`ifdef REEL_SNAP_EN
    assign finish_s = (cnt_r == T_LAST) && all_aligned_s;
`else
    assign finish_s = (cnt_r == T_LAST);
`endif

    // Spin timer, direction latch, done pulse and reel positions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= '0;
            pos_r  <= '0;
            dir_r  <= 1'b1;
            done_r <= 1'b0;
`ifdef REEL_SNAP_EN
            past_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            pos_r  <= nxt_pos_s;
            if (cnt_r == '0) begin
                if (bus.up || bus.down) begin
                    cnt_r <= CNT_W'(1);
                    dir_r <= bus.up;
                end
            end else if (finish_s) begin
                cnt_r  <= '0;
                done_r <= 1'b1;
`ifdef REEL_SNAP_EN
                past_r <= 1'b0;
`endif
            end else if (cnt_r != T_LAST) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
`ifdef REEL_SNAP_EN
                past_r <= 1'b1;
`endif
            end
        end
    end

    assign bus.pos    = pos_r;
    assign bus.moving = moving_s;
    assign bus.busy   = (cnt_r != '0);
    assign bus.done   = done_r;
    assign bus.dir    = dir_r;

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Scoreboard bench for reel_spin_ctrl: expected final offsets are queued at request time
// and compared when the done pulse appears. Build with REEL_SNAP_EN to check snapping.
module tb_reel_spin_ctrl;
    localparam int NR = 3;
    localparam int PW = 5;

`ifdef REEL_SNAP_EN
    localparam int DONE_EDGE = 21;
    localparam int STOP0 = 12, STOP1 = 16, STOP2 = 20;
    localparam logic [NR*PW-1:0] POS_DOWN = {5'd12, 5'd0, 5'd4};
    localparam logic [NR*PW-1:0] POS_UP   = {5'd4,  5'd0, 5'd12};
`else
    localparam int DONE_EDGE = 19;
    localparam int STOP0 = 10, STOP1 = 14, STOP2 = 18;
    localparam logic [NR*PW-1:0] POS_DOWN = {5'd10, 5'd14, 5'd2};
    localparam logic [NR*PW-1:0] POS_UP   = {5'd6,  5'd2,  5'd14};
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [NR*PW-1:0] exp_q[$];

    reel_spin_ctrl_if #(.NUM_REELS(NR), .POS_W(PW)) bus ();

    reel_spin_ctrl #(
        .NUM_REELS(NR), .POS_W(PW), .WRAP(16), .CNT_W(6), .ACCEL(2),
        .BASE_STOP(10), .STAGGER(4), .SLOW_SPD(1), .MID_SPD(2), .FAST_SPD(3), .SYM_H(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        bus.up   = 1'b0;
        bus.down = 1'b0;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_req(input logic u, input logic d);
        @(negedge clk);
        bus.up   = u;
        bus.down = d;
        @(negedge clk);
        bus.up   = 1'b0;
        bus.down = 1'b0;
    endtask

    // Follows one spin from the negedge after its start edge; optionally injects a mid-spin down.
    task automatic wait_spin(input string name, input logic exp_dir, input int inject_at);
        int               edge_n;
        bit               seen;
        logic [NR-1:0]    exp_mv;
        logic [NR*PW-1:0] exp_pos;
        edge_n = 1;
        seen   = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, bus.busy);
        end
        while (!seen && edge_n < 60) begin
            exp_mv = {edge_n <= STOP2, edge_n <= STOP1, edge_n <= STOP0};
            tests++;
            if (bus.moving !== exp_mv) begin
                fails++;
                $display("FAIL %s moving@%0d: got %b expected %b", name, edge_n, bus.moving, exp_mv);
            end
            tests++;
            if (bus.dir !== exp_dir) begin
                fails++;
                $display("FAIL %s dir@%0d: got %b expected %b", name, edge_n, bus.dir, exp_dir);
            end
            bus.down = (edge_n == inject_at);
            @(negedge clk);
            edge_n++;
            seen = (bus.done === 1'b1);
        end
        bus.down = 1'b0;
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s done_timeout: got no done after %0d edges expected done", name, edge_n);
        end
        tests++;
        if (edge_n != DONE_EDGE) begin
            fails++;
            $display("FAIL %s done_edge: got %0d expected %0d", name, edge_n, DONE_EDGE);
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy_at_done: got %b expected 0", name, bus.busy);
        end
        exp_pos = exp_q.pop_front();
        tests++;
        if (bus.pos !== exp_pos) begin
            fails++;
            $display("FAIL %s final_pos: got %h expected %h", name, bus.pos, exp_pos);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL %s done_clear: got %b expected 0", name, bus.done);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (bus.pos !== '0) begin
            fails++;
            $display("FAIL reset pos: got %h expected 0", bus.pos);
        end
        tests++;
        if ({bus.busy, bus.done, bus.moving} !== 5'b00000) begin
            fails++;
            $display("FAIL reset busy_done_moving: got %b expected 00000", {bus.busy, bus.done, bus.moving});
        end
        tests++;
        if (bus.dir !== 1'b1) begin
            fails++;
            $display("FAIL reset dir: got %b expected 1", bus.dir);
        end
    endtask

    task automatic test_down();
        apply_reset();
        exp_q.push_back(POS_DOWN);
        start_req(1'b0, 1'b1);
        wait_spin("down", 1'b0, 0);
    endtask

    task automatic test_up();
        apply_reset();
        exp_q.push_back(POS_UP);
        start_req(1'b1, 1'b0);
        wait_spin("up", 1'b1, 0);
    endtask

    task automatic test_both();
        apply_reset();
        exp_q.push_back(POS_UP);
        start_req(1'b1, 1'b1);
        wait_spin("both", 1'b1, 0);
    endtask

    task automatic test_ignore_mid_spin();
        apply_reset();
        exp_q.push_back(POS_DOWN);
        start_req(1'b0, 1'b1);
        wait_spin("ignore", 1'b0, 5);
    endtask

    task automatic test_reset_mid_spin();
        apply_reset();
        start_req(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (bus.pos !== '0) begin
            fails++;
            $display("FAIL midreset pos: got %h expected 0", bus.pos);
        end
        tests++;
        if ({bus.busy, bus.done, bus.moving} !== 5'b00000) begin
            fails++;
            $display("FAIL midreset busy_done_moving: got %b expected 00000", {bus.busy, bus.done, bus.moving});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.push_back(POS_DOWN);
        start_req(1'b0, 1'b1);
        wait_spin("after_reset", 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        // The second spin starts from the first spin's final offsets.
        logic [NR*PW-1:0] first_pos;
        logic [NR*PW-1:0] back_pos;
        apply_reset();
        exp_q.push_back(POS_DOWN);
        start_req(1'b0, 1'b1);
        wait_spin("b2b_first", 1'b0, 0);
        first_pos = POS_DOWN;
        for (int i = 0; i < NR; i++) begin
            back_pos[i*PW +: PW] = PW'((int'(first_pos[i*PW +: PW]) + 16 - int'(POS_DOWN[i*PW +: PW])) % 16);
        end
        exp_q.push_back(back_pos);
        start_req(1'b1, 1'b0);
        wait_spin("b2b_second", 1'b1, 0);
    endtask

    initial begin
        bus.up   = 1'b0;
        bus.down = 1'b0;
        test_reset();
        test_down();
        test_up();
        test_both();
        test_ignore_mid_spin();
        test_reset_mid_spin();
`ifndef REEL_SNAP_EN
        test_back_to_back();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
